// File: rtl/snes_pad_reader.sv
// rtl/snes_pad_reader.sv - NES/SNES pad poller: latch/clock generation, serial capture, registered button state.
// Frame outputs are registered from the next state so they change in the same cycle as the FSM state.
module snes_pad_reader #(
    parameter int HALF_TICKS   = 300,
    parameter int LATCH_TICKS  = 600,
    parameter int PERIOD_TICKS = 833333
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  Mode,
    input  logic        Data,
    output logic        Strobe_Latch,
    output logic        Shift_Clock,
    output logic        Up,
    output logic        Down,
    output logic        Left,
    output logic        Right,
    output logic [15:0] Buttons,
    output logic        Readable
);
    localparam int MAXT = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
    localparam int TW   = $clog2(MAXT + 1);
    localparam int CW   = $clog2(PERIOD_TICKS + 1);
    localparam logic [TW-1:0] LATCH_LAST  = TW'(LATCH_TICKS - 1);
    localparam logic [TW-1:0] HALF_LAST   = TW'(HALF_TICKS - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(PERIOD_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_sync;
    logic [1:0]      r_frame_mode;
    logic            r_nes;
    logic [3:0]      r_idx;
    logic [TW-1:0]   r_tick;
    logic [CW-1:0]   r_period;
    logic [15:0]     r_shift;
    logic            r_latch, r_sclk, r_up, r_down, r_left, r_right, r_ready;
    logic [15:0]     r_buttons;

    logic w_mode_ok, w_start, w_abort, w_clear, w_sample, w_advance, w_publish, w_last_bit;

    assign w_mode_ok  = (Mode == 2'b01) || (Mode == 2'b10);
    assign w_last_bit = (r_idx == (r_nes ? 4'd7 : 4'd15));

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_abort   = 1'b0;
        w_clear   = 1'b0;
        w_sample  = 1'b0;
        w_advance = 1'b0;
        w_publish = 1'b0;
        if ((r_state inside {S_LATCH, S_LOW, S_HIGH}) && (Mode != r_frame_mode)) begin
            w_next  = S_IDLE;
            w_abort = 1'b1;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mode_ok && (r_period == '0)) begin
                        w_next  = S_LATCH;
                        w_start = 1'b1;
                    end else if (!w_mode_ok) begin
                        w_clear = 1'b1;
                    end
                end
                S_LATCH: if (r_tick == LATCH_LAST) w_next = S_LOW;
                S_LOW: begin
                    if (r_tick == HALF_LAST) begin
                        w_next   = S_HIGH;
                        w_sample = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_tick == HALF_LAST) begin
                        if (w_last_bit) begin
                            w_next    = S_DONE;
                            w_publish = 1'b1;
                        end else begin
                            w_next    = S_LOW;
                            w_advance = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // A period shorter than the frame restarts straight out of DONE.
                    if (w_mode_ok && (r_period == '0)) begin
                        w_next  = S_LATCH;
                        w_start = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_sync       <= 2'b11;
            r_frame_mode <= 2'b00;
            r_nes        <= 1'b0;
            r_idx        <= 4'd0;
            r_tick       <= '0;
            r_period     <= '0;
            r_shift      <= 16'h0000;
            r_latch      <= 1'b0;
            r_sclk       <= 1'b1;
            r_ready      <= 1'b0;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_buttons    <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[0], Data};
            r_tick  <= (w_next != r_state) ? '0 : r_tick + 1'b1;

            if (w_start) begin
                r_frame_mode <= Mode;
                r_nes        <= (Mode == 2'b01);
                r_idx        <= 4'd0;
                r_shift      <= 16'h0000;
                r_period     <= PERIOD_LOAD;
            end else if (w_abort) begin
                r_period <= '0;
            end else if (r_period != '0) begin
                r_period <= r_period - 1'b1;
            end

            if (w_sample)  r_shift[r_idx] <= ~r_sync[1];
            if (w_advance) r_idx <= r_idx + 1'b1;

            r_latch <= (w_next == S_LATCH);
            r_sclk  <= (w_next != S_LOW);
            r_ready <= (w_next == S_DONE);

            if (w_clear) begin
                r_buttons <= 16'h0000;
                r_up      <= 1'b0;
                r_down    <= 1'b0;
                r_left    <= 1'b0;
                r_right   <= 1'b0;
            end else if (w_publish) begin
                r_buttons <= r_nes ? {8'h00, r_shift[7:0]} : r_shift;
                r_up      <= r_shift[4];
                r_down    <= r_shift[5];
                r_left    <= r_shift[6];
                r_right   <= r_shift[7];
            end
        end
    end

    assign Strobe_Latch = r_latch;
    assign Shift_Clock  = r_sclk;
    assign Readable     = r_ready;
    assign Buttons      = r_buttons;
    assign Up           = r_up;
    assign Down         = r_down;
    assign Left         = r_left;
    assign Right        = r_right;
endmodule

// File: tb/tb_snes_pad_reader.sv
// tb/tb_snes_pad_reader.sv - scoreboard bench for snes_pad_reader with a serial pad model.
module tb_snes_pad_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, data;
    logic [1:0]  mode;
    logic        lat, sck, up, down, left, right, rdy;
    logic [15:0] btn;

    logic        rst50, data50;
    logic [1:0]  mode50;
    logic        lat50, sck50, up50, down50, left50, right50, rdy50;
    logic [15:0] btn50;

    snes_pad_reader #(.HALF_TICKS(4), .LATCH_TICKS(8), .PERIOD_TICKS(200)) dut (
        .CLK(clk), .RST(rst), .Mode(mode), .Data(data),
        .Strobe_Latch(lat), .Shift_Clock(sck), .Up(up), .Down(down), .Left(left), .Right(right),
        .Buttons(btn), .Readable(rdy)
    );

    snes_pad_reader #(.HALF_TICKS(4), .LATCH_TICKS(8), .PERIOD_TICKS(50)) dut50 (
        .CLK(clk), .RST(rst50), .Mode(mode50), .Data(data50),
        .Strobe_Latch(lat50), .Shift_Clock(sck50), .Up(up50), .Down(down50), .Left(left50), .Right(right50),
        .Buttons(btn50), .Readable(rdy50)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] b;
        logic [3:0]  d;
        logic [7:0]  rel;
        logic [4:0]  p;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] b, input logic [3:0] d, input int rel, input int p);
        exp_t e;
        e.b = b; e.d = d; e.rel = 8'(rel); e.p = 5'(p);
        sb.push_back(e);
    endtask

    // Pad model: bit 0 is presented while latched, each shift-clock rise advances one bit.
    logic [15:0] pad_bits = 16'h0000;
    int          pidx = 0;
    logic        pad_prev_sck = 1'b1;
    always @(negedge clk) begin
        if (lat) pidx = 0;
        else if (sck && !pad_prev_sck) pidx++;
        pad_prev_sck = sck;
        data = (pidx < 16) ? ~pad_bits[pidx] : 1'b0;
    end

    int   t_latch = 0, t_prev = 0, rises = 0, lat_len = 0, pulses = 0;
    logic prev_lat = 1'b0, prev_sck = 1'b1;
    always @(negedge clk) begin
        if (lat && !prev_lat) begin
            t_prev  = t_latch;
            t_latch = cyc;
            rises++;
            pulses  = 0;
            lat_len = 0;
        end
        if (lat) lat_len++;
        if (!lat && prev_lat) chk("latch_width", 32'(lat_len), 32'd8);
        if (!sck && prev_sck) pulses++;
        if (rdy) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_readable: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("buttons", 32'(btn), 32'(mon_e.b));
                chk("dpad_udlr", 32'({up, down, left, right}), 32'(mon_e.d));
                chk("readable_cycle", 32'(cyc - t_latch), 32'(mon_e.rel));
                chk("shift_pulses", 32'(pulses), 32'(mon_e.p));
            end
        end
        prev_lat = lat;
        prev_sck = sck;
    end

    task automatic wait_readable(input string name, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy && n < max);
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no Readable within %0d cycles expected a pulse", name, max);
        end
    endtask

    task automatic wait_latch(input string name, input int max);
        int n = 0;
        int r0 = rises;
        do begin
            @(negedge clk);
            n++;
        end while (rises == r0 && n < max);
        if (rises == r0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no latch within %0d cycles expected one", name, max);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_latch"}, 32'(lat), 32'd0);
        chk({tag, "_sclk"}, 32'(sck), 32'd1);
        chk({tag, "_buttons"}, 32'(btn), 32'd0);
        chk({tag, "_dpad"}, 32'({up, down, left, right}), 32'd0);
        chk({tag, "_readable"}, 32'(rdy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, t0, tr, t1;
        rst = 1'b1; mode = 2'b10;
        rst50 = 1'b1; mode50 = 2'b10; data50 = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        // Frame 1: nothing pressed, SNES.
        push_exp(16'h0000, 4'b0000, 136, 16);
        rst = 1'b0;
        wait_readable("frame1", 400);

        // Frame 2: Up (bit 4) and A (bit 8).
        pad_bits = 16'h0110;
        push_exp(16'h0110, 4'b1000, 136, 16);
        wait_latch("frame2_latch", 300);
        chk("period_gap", 32'(t_latch - t_prev), 32'd200);
        wait_readable("frame2", 400);
        repeat (20) @(negedge clk);
        chk("hold_buttons", 32'(btn), 32'h0110);
        chk("hold_up", 32'(up), 32'd1);

        // Frame 3: NES, bits 6 and 0.
        mode = 2'b01;
        pad_bits = 16'h0041;
        push_exp(16'h0041, 4'b0010, 72, 8);
        wait_readable("frame3", 400);

        // Abort during bit 9 of an SNES frame.
        mode = 2'b10;
        pad_bits = 16'h0000;
        wait_latch("abort_latch", 300);
        while (cyc < t_latch + 82) @(negedge clk);
        mode = 2'b00;
        @(negedge clk);
        check_idle_outputs("abort");
        r0 = rises;
        repeat (300) @(negedge clk);
        chk("no_latch_while_off", 32'(rises - r0), 32'd0);

        // Fresh frame starts immediately, then RST mid-LOW.
        mode = 2'b10;
        pad_bits = 16'h0010;
        push_exp(16'h0010, 4'b1000, 136, 16);
        wait_readable("frame_pre_rst", 400);
        wait_latch("rst_latch", 300);
        while (cyc < t_latch + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        push_exp(16'h0010, 4'b1000, 136, 16);
        @(negedge clk);
        chk("latch_after_rst", 32'(lat), 32'd1);
        wait_readable("frame_post_rst", 400);

        // Short period: second latch directly follows DONE.
        rst50 = 1'b0;
        t0 = -1; tr = -1; t1 = -1;
        for (int n = 0; n < 400 && t1 < 0; n++) begin
            @(negedge clk);
            if (lat50 && t0 < 0) t0 = cyc;
            if (rdy50 && tr < 0) tr = cyc;
            if (lat50 && tr >= 0 && t1 < 0) t1 = cyc;
        end
        chk("p50_readable_cycle", 32'(tr - t0), 32'd136);
        chk("p50_gap", 32'(t1 - t0), 32'd137);
        chk("p50_buttons", 32'(btn50), 32'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
